// File: rtl/stream_serializer_if.sv
// Parallel-in valid/ready handshake plus the serial-out bundle of stream_serializer.
interface stream_serializer_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic [WIDTH-1:0] par_in;
  logic             par_valid;
  logic             par_ready;
  logic             serial_out;
  logic             serial_valid;
  logic             frame_start;
  logic             busy;

  modport master (
    output par_in, par_valid,
    input  par_ready, serial_out, serial_valid, frame_start, busy
  );

  modport slave (
    input  par_in, par_valid,
    output par_ready, serial_out, serial_valid, frame_start, busy
  );
endinterface

// File: rtl/stream_serializer.sv
// Double-buffered parallel-to-serial converter: a holding register feeds a shift
// register so consecutive words leave as one gap-free bit stream.
module stream_serializer #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          MSB_FIRST  = 1'b0,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  stream_serializer_if.slave  bus
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] hold_reg, hold_nxt;
  logic [WIDTH-1:0] shift_reg, shift_nxt;
  logic [CW-1:0]    bit_cnt, bit_cnt_nxt;
  logic             hold_full, hold_full_nxt;
  logic             first, first_nxt;
  logic             active, last, take, accept;

  assign active = (state == ST_SHIFT);
  assign last   = active && (bit_cnt == LAST_CNT);
  // The held word moves into the shifter when the shifter is free or finishing.
  assign take   = hold_full && (!active || last);
  assign accept = bus.par_valid && bus.par_ready;

  assign bus.par_ready    = !reset && (!hold_full || take);
  assign bus.serial_out   = active ? (MSB_FIRST ? shift_reg[WIDTH-1] : shift_reg[0]) : IDLE_LEVEL;
  assign bus.serial_valid = active;
  assign bus.frame_start  = active && first;
  assign bus.busy         = active || hold_full;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      hold_reg  <= '0;
      shift_reg <= '0;
      bit_cnt   <= '0;
      hold_full <= 1'b0;
      first     <= 1'b0;
    end else begin
      state     <= state_nxt;
      hold_reg  <= hold_nxt;
      shift_reg <= shift_nxt;
      bit_cnt   <= bit_cnt_nxt;
      hold_full <= hold_full_nxt;
      first     <= first_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    hold_nxt      = hold_reg;
    shift_nxt     = shift_reg;
    bit_cnt_nxt   = bit_cnt;
    hold_full_nxt = hold_full;
    first_nxt     = first;

    if (take) begin
      state_nxt     = ST_SHIFT;
      shift_nxt     = hold_reg;
      bit_cnt_nxt   = '0;
      first_nxt     = 1'b1;
      hold_full_nxt = 1'b0;
    end else if (active && !last) begin
      bit_cnt_nxt = bit_cnt + CW'(1);
      shift_nxt   = MSB_FIRST ? (shift_reg << 1) : (shift_reg >> 1);
      first_nxt   = 1'b0;
    end else if (last) begin
      state_nxt   = ST_IDLE;
      bit_cnt_nxt = '0;
      first_nxt   = 1'b0;
    end

    // A refill on the same edge as a take keeps the holding register full.
    if (accept) begin
      hold_nxt      = bus.par_in;
      hold_full_nxt = 1'b1;
    end
  end
endmodule

// File: tb/tb_stream_serializer.sv
// Self-checking bench: four builds of stream_serializer compared against a
// word-queue reference of the expected serial stream.
module tb_stream_serializer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  stream_serializer_if #(.WIDTH(8)) b0 ();
  stream_serializer_if #(.WIDTH(8)) b1 ();
  stream_serializer_if #(.WIDTH(1)) b2 ();
  stream_serializer_if #(.WIDTH(5)) b3 ();

  stream_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u0 (.clk(clk), .reset(reset), .bus(b0));
  stream_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u1 (.clk(clk), .reset(reset), .bus(b1));
  stream_serializer #(.WIDTH(1), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u2 (.clk(clk), .reset(reset), .bus(b2));
  stream_serializer #(.WIDTH(5), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u3 (.clk(clk), .reset(reset), .bus(b3));

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [7:0] acc_w[4][$];
  int         acc_c[4][$];
  bit         obs_b[4][$];
  bit         obs_f[4][$];
  int         obs_c[4][$];
  int         idle_bad[4];
  int         rdy_busy[4];
  bit         exp_b[$];
  bit         exp_f[$];

  function automatic int width_of(int d);
    case (d)
      2:       return 1;
      3:       return 5;
      default: return 8;
    endcase
  endfunction

  function automatic logic idle_of(int d);
    return (d == 1);
  endfunction

  function automatic void log_cycle(int d, logic pv, logic rdy, logic [7:0] pin,
                                    logic sv, logic so, logic fs, logic bz);
    if (pv && rdy) begin
      acc_w[d].push_back(pin);
      acc_c[d].push_back(cyc);
    end
    if (sv) begin
      obs_b[d].push_back(so);
      obs_f[d].push_back(fs);
      obs_c[d].push_back(cyc);
    end else if (so !== idle_of(d) || fs !== 1'b0) begin
      idle_bad[d]++;
    end
    if (rdy && pv && bz) rdy_busy[d]++;
  endfunction

  // Cycle log: handshakes and line state sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      log_cycle(0, b0.par_valid, b0.par_ready, b0.par_in, b0.serial_valid, b0.serial_out, b0.frame_start, b0.busy);
      log_cycle(1, b1.par_valid, b1.par_ready, b1.par_in, b1.serial_valid, b1.serial_out, b1.frame_start, b1.busy);
      log_cycle(2, b2.par_valid, b2.par_ready, 8'(b2.par_in), b2.serial_valid, b2.serial_out, b2.frame_start, b2.busy);
      log_cycle(3, b3.par_valid, b3.par_ready, 8'(b3.par_in), b3.serial_valid, b3.serial_out, b3.frame_start, b3.busy);
    end
  end

  // Reference: the serial stream is the concatenation of accepted words in order.
  function automatic void build_exp(int d);
    int w;
    logic [7:0] wd;
    w = width_of(d);
    exp_b.delete();
    exp_f.delete();
    for (int k = 0; k < acc_w[d].size(); k++) begin
      wd = acc_w[d][k];
      for (int i = 0; i < w; i++) begin
        exp_b.push_back(wd[(d == 1) ? (w - 1 - i) : i]);
        exp_f.push_back(i == 0);
      end
    end
  endfunction

  function automatic void clear_logs();
    for (int d = 0; d < 4; d++) begin
      acc_w[d].delete(); acc_c[d].delete();
      obs_b[d].delete(); obs_f[d].delete(); obs_c[d].delete();
      idle_bad[d] = 0; rdy_busy[d] = 0;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(int d, logic pv, logic [7:0] w);
    case (d)
      0: begin b0.par_valid = pv; b0.par_in = w; end
      1: begin b1.par_valid = pv; b1.par_in = w; end
      2: begin b2.par_valid = pv; b2.par_in = w[0]; end
      default: begin b3.par_valid = pv; b3.par_in = w[4:0]; end
    endcase
  endtask

  function automatic logic rdy(int d);
    case (d)
      0: return b0.par_ready;
      1: return b1.par_ready;
      2: return b2.par_ready;
      default: return b3.par_ready;
    endcase
  endfunction

  // Present a word and hold it until an accept edge passes (bounded wait).
  task automatic send(int d, logic [7:0] w, output bit ok);
    ok = 1'b0;
    set_in(d, 1'b1, w);
    for (int i = 0; i < 40; i++) begin
      if (rdy(d)) begin
        tick();
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 4; d++) set_in(d, 1'b0, 8'h00);
    reset = 1'b1;
    tick(); tick();
    n_chk++; if (b0.par_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", b0.par_ready); end
    n_chk++; if (b0.serial_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", b0.serial_valid); end
    n_chk++; if (b0.serial_out !== 1'b0) begin n_fail++; $display("FAIL rst_out: got %b want 0", b0.serial_out); end
    n_chk++; if (b0.frame_start !== 1'b0) begin n_fail++; $display("FAIL rst_start: got %b want 0", b0.frame_start); end
    n_chk++; if (b0.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", b0.busy); end
    n_chk++; if (b1.serial_out !== 1'b1) begin n_fail++; $display("FAIL rst_idle_hi: got %b want 1", b1.serial_out); end
    reset = 1'b0;
    #1;
    n_chk++; if (b0.par_ready !== 1'b1) begin n_fail++; $display("FAIL rel_ready_w8: got %b want 1", b0.par_ready); end
    n_chk++; if (b2.par_ready !== 1'b1) begin n_fail++; $display("FAIL rel_ready_w1: got %b want 1", b2.par_ready); end
    n_chk++; if (b3.par_ready !== 1'b1) begin n_fail++; $display("FAIL rel_ready_w5: got %b want 1", b3.par_ready); end
    tick();
  endtask

  task automatic test_single();
    bit ok;
    clear_logs();
    send(0, 8'hA5, ok);
    set_in(0, 1'b0, 8'h00);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL single_accept: got timeout want accept"); end
    repeat (14) tick();
    build_exp(0);
    n_chk++; if (obs_b[0].size() != 8) begin n_fail++; $display("FAIL single_len: got %0d bits want 8", obs_b[0].size()); end
    for (int i = 0; i < exp_b.size() && i < obs_b[0].size(); i++) begin
      n_chk++;
      if ({obs_b[0][i], obs_f[0][i]} !== {exp_b[i], exp_f[i]}) begin
        n_fail++; $display("FAIL single_bit%0d: got data,start %b%b want %b%b", i, obs_b[0][i], obs_f[0][i], exp_b[i], exp_f[i]);
      end
    end
    if (obs_c[0].size() == 8 && acc_c[0].size() == 1) begin
      n_chk++; if (obs_c[0][0] - acc_c[0][0] != 2) begin n_fail++; $display("FAIL single_latency: got %0d want 2", obs_c[0][0] - acc_c[0][0]); end
      n_chk++; if (obs_c[0][7] - obs_c[0][0] != 7) begin n_fail++; $display("FAIL single_span: got %0d want 7", obs_c[0][7] - obs_c[0][0]); end
    end
    n_chk++; if (idle_bad[0] != 0) begin n_fail++; $display("FAIL single_idle: got %0d bad idle cycles want 0", idle_bad[0]); end
    n_chk++; if ({b0.serial_valid, b0.serial_out} !== 2'b00) begin n_fail++; $display("FAIL single_after: got %b%b want 00", b0.serial_valid, b0.serial_out); end
  endtask

  task automatic test_back_to_back();
    bit ok0, ok1, ok2;
    clear_logs();
    send(0, 8'h01, ok0);
    send(0, 8'h80, ok1);
    send(0, 8'hFF, ok2);
    set_in(0, 1'b0, 8'h00);
    n_chk++; if (!(ok0 && ok1 && ok2)) begin n_fail++; $display("FAIL b2b_accept: got %b%b%b want 111", ok0, ok1, ok2); end
    repeat (30) tick();
    build_exp(0);
    n_chk++; if (obs_b[0].size() != 24) begin n_fail++; $display("FAIL b2b_len: got %0d bits want 24", obs_b[0].size()); end
    for (int i = 0; i < exp_b.size() && i < obs_b[0].size(); i++) begin
      n_chk++;
      if ({obs_b[0][i], obs_f[0][i]} !== {exp_b[i], exp_f[i]}) begin
        n_fail++; $display("FAIL b2b_bit%0d: got data,start %b%b want %b%b", i, obs_b[0][i], obs_f[0][i], exp_b[i], exp_f[i]);
      end
    end
    if (obs_c[0].size() == 24) begin
      n_chk++; if (obs_c[0][23] - obs_c[0][0] != 23) begin n_fail++; $display("FAIL b2b_gapfree: got span %0d want 23", obs_c[0][23] - obs_c[0][0]); end
    end
    n_chk++; if (rdy_busy[0] != 2) begin n_fail++; $display("FAIL b2b_ready_busy: got %0d want 2", rdy_busy[0]); end
  endtask

  task automatic test_msb_idle();
    bit ok;
    clear_logs();
    n_chk++; if ({b1.serial_valid, b1.serial_out} !== 2'b01) begin n_fail++; $display("FAIL msb_idle_before: got %b%b want 01", b1.serial_valid, b1.serial_out); end
    send(1, 8'hC3, ok);
    set_in(1, 1'b0, 8'h00);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL msb_accept: got timeout want accept"); end
    repeat (14) tick();
    build_exp(1);
    n_chk++; if (obs_b[1].size() != 8) begin n_fail++; $display("FAIL msb_len: got %0d bits want 8", obs_b[1].size()); end
    for (int i = 0; i < exp_b.size() && i < obs_b[1].size(); i++) begin
      n_chk++;
      if ({obs_b[1][i], obs_f[1][i]} !== {exp_b[i], exp_f[i]}) begin
        n_fail++; $display("FAIL msb_bit%0d: got data,start %b%b want %b%b", i, obs_b[1][i], obs_f[1][i], exp_b[i], exp_f[i]);
      end
    end
    n_chk++; if (idle_bad[1] != 0) begin n_fail++; $display("FAIL msb_idle: got %0d bad idle cycles want 0", idle_bad[1]); end
    n_chk++; if ({b1.serial_valid, b1.serial_out} !== 2'b01) begin n_fail++; $display("FAIL msb_idle_after: got %b%b want 01", b1.serial_valid, b1.serial_out); end
  endtask

  task automatic test_backpressure();
    clear_logs();
    for (int i = 0; i < 40; i++) begin
      set_in(0, 1'b1, 8'($urandom));
      tick();
    end
    set_in(0, 1'b0, 8'h00);
    for (int i = 0; i < 100; i++) begin
      if (!b0.busy) break;
      tick();
    end
    n_chk++; if (b0.busy !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got busy %b want 0", b0.busy); end
    repeat (3) tick();
    build_exp(0);
    n_chk++; if (acc_w[0].size() != 6) begin n_fail++; $display("FAIL bp_accepts: got %0d want 6", acc_w[0].size()); end
    n_chk++; if (obs_b[0].size() != exp_b.size()) begin n_fail++; $display("FAIL bp_len: got %0d bits want %0d", obs_b[0].size(), exp_b.size()); end
    for (int i = 0; i < exp_b.size() && i < obs_b[0].size(); i++) begin
      n_chk++;
      if ({obs_b[0][i], obs_f[0][i]} !== {exp_b[i], exp_f[i]}) begin
        n_fail++; $display("FAIL bp_bit%0d: got data,start %b%b want %b%b", i, obs_b[0][i], obs_f[0][i], exp_b[i], exp_f[i]);
      end
    end
    if (obs_c[0].size() == 48) begin
      n_chk++; if (obs_c[0][47] - obs_c[0][0] != 47) begin n_fail++; $display("FAIL bp_gapfree: got span %0d want 47", obs_c[0][47] - obs_c[0][0]); end
    end
    n_chk++; if ({b0.serial_valid, b0.serial_out} !== 2'b00) begin n_fail++; $display("FAIL bp_underrun: got %b%b want 00", b0.serial_valid, b0.serial_out); end
    n_chk++; if (idle_bad[0] != 0) begin n_fail++; $display("FAIL bp_idle: got %0d bad idle cycles want 0", idle_bad[0]); end
  endtask

  task automatic test_mid_reset();
    bit ok0, ok1, found;
    clear_logs();
    send(0, 8'h5A, ok0);
    send(0, 8'h3C, ok1);
    set_in(0, 1'b0, 8'h00);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (b0.serial_valid && obs_b[0].size() == 3) begin found = 1'b1; break; end
      tick();
    end
    n_chk++; if (!(ok0 && ok1 && found)) begin n_fail++; $display("FAIL mrst_setup: got %b%b%b want 111", ok0, ok1, found); end
    reset = 1'b1;
    tick();
    n_chk++; if ({b0.serial_valid, b0.busy, b0.par_ready, b0.frame_start} !== 4'b0000) begin
      n_fail++; $display("FAIL mrst_state: got valid,busy,ready,start %b%b%b%b want 0000", b0.serial_valid, b0.busy, b0.par_ready, b0.frame_start);
    end
    reset = 1'b0;
    #1;
    n_chk++; if (b0.par_ready !== 1'b1) begin n_fail++; $display("FAIL mrst_ready: got %b want 1", b0.par_ready); end
    tick();
    clear_logs();
    send(0, 8'h0F, ok0);
    set_in(0, 1'b0, 8'h00);
    repeat (14) tick();
    build_exp(0);
    n_chk++; if (acc_w[0].size() != 1) begin n_fail++; $display("FAIL mrst_accepts: got %0d want 1", acc_w[0].size()); end
    n_chk++; if (obs_b[0].size() != 8) begin n_fail++; $display("FAIL mrst_len: got %0d bits want 8", obs_b[0].size()); end
    for (int i = 0; i < exp_b.size() && i < obs_b[0].size(); i++) begin
      n_chk++;
      if ({obs_b[0][i], obs_f[0][i]} !== {exp_b[i], exp_f[i]}) begin
        n_fail++; $display("FAIL mrst_bit%0d: got data,start %b%b want %b%b", i, obs_b[0][i], obs_f[0][i], exp_b[i], exp_f[i]);
      end
    end
  endtask

  task automatic test_width1();
    bit ok, all_ok;
    clear_logs();
    all_ok = 1'b1;
    for (int k = 0; k < 12; k++) begin
      send(2, 8'($urandom_range(0, 1)), ok);
      all_ok &= ok;
    end
    set_in(2, 1'b0, 8'h00);
    repeat (6) tick();
    build_exp(2);
    n_chk++; if (!all_ok) begin n_fail++; $display("FAIL w1_accept: got timeout want accept"); end
    n_chk++; if (obs_b[2].size() != 12) begin n_fail++; $display("FAIL w1_len: got %0d bits want 12", obs_b[2].size()); end
    for (int i = 0; i < exp_b.size() && i < obs_b[2].size(); i++) begin
      n_chk++;
      if ({obs_b[2][i], obs_f[2][i]} !== {exp_b[i], exp_f[i]}) begin
        n_fail++; $display("FAIL w1_bit%0d: got data,start %b%b want %b%b", i, obs_b[2][i], obs_f[2][i], exp_b[i], exp_f[i]);
      end
    end
    if (obs_c[2].size() == 12) begin
      n_chk++; if (obs_c[2][11] - obs_c[2][0] != 11) begin n_fail++; $display("FAIL w1_gapfree: got span %0d want 11", obs_c[2][11] - obs_c[2][0]); end
    end
  endtask

  task automatic test_width5();
    bit ok0, ok1, ok2;
    logic [4:0] first5;
    clear_logs();
    send(3, 8'h13, ok0);
    send(3, 8'($urandom), ok1);
    send(3, 8'($urandom), ok2);
    set_in(3, 1'b0, 8'h00);
    repeat (20) tick();
    build_exp(3);
    n_chk++; if (!(ok0 && ok1 && ok2)) begin n_fail++; $display("FAIL w5_accept: got %b%b%b want 111", ok0, ok1, ok2); end
    n_chk++; if (obs_b[3].size() != 15) begin n_fail++; $display("FAIL w5_len: got %0d bits want 15", obs_b[3].size()); end
    for (int i = 0; i < exp_b.size() && i < obs_b[3].size(); i++) begin
      n_chk++;
      if ({obs_b[3][i], obs_f[3][i]} !== {exp_b[i], exp_f[i]}) begin
        n_fail++; $display("FAIL w5_bit%0d: got data,start %b%b want %b%b", i, obs_b[3][i], obs_f[3][i], exp_b[i], exp_f[i]);
      end
    end
    if (obs_b[3].size() >= 5) begin
      first5 = {obs_b[3][0], obs_b[3][1], obs_b[3][2], obs_b[3][3], obs_b[3][4]};
      n_chk++; if (first5 !== 5'b11001) begin n_fail++; $display("FAIL w5_0x13: got sequence %b want 11001", first5); end
    end
  endtask

  initial begin
    for (int d = 0; d < 4; d++) set_in(d, 1'b0, 8'h00);
    clear_logs();
    test_reset();
    test_single();
    test_back_to_back();
    test_msb_idle();
    test_backpressure();
    test_mid_reset();
    test_width1();
    test_width5();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want completion by 200000");
    $fatal(1, "watchdog expired");
  end
endmodule
